booth_seq_mul: RTL
==================

// Module: booth_seq_mul
// PURPOSE
//   Multi-cycle signed radix-2 Booth multiplier sequencer for the CPU MUL instruction.
//   Holds operand, accumulator and step-count registers; performs one Booth step per clock.
//   Runs a start/busy/done handshake with the control unit and drives a 2*WIDTH-bit product.
//   The product is split into hi/lo words for the HI/LO register writeback.
// PARAMETERS
//   WIDTH  32  operand width in bits; product is 2*WIDTH bits; one step per operand bit
// PORTS
//   clock         in   1        system clock, all state updates on rising edge
//   clear         in   1        asynchronous, active-high reset
//   start         in   1        request a multiply; sampled only in IDLE
//   multiplicand  in   WIDTH    signed operand M, captured on the accepting edge
//   multiplier    in   WIDTH    signed operand Q, captured on the accepting edge
//   busy          out  1        high while state != IDLE
//   done          out  1        one-cycle pulse: product valid, HI/LO write enable
//   hi_out        out  WIDTH    product[2*WIDTH-1:WIDTH]
//   lo_out        out  WIDTH    product[WIDTH-1:0]
// BEHAVIOUR
//   Reset: clock and reset are as decided above. On clear=1 (async), the block enters IDLE.
//     Step count = 0. busy = 0. done = 0. hi_out = lo_out = 0.
//     All internal registers (M, A, Q, q_1) are 0.
//   States: IDLE -> RUN -> DONE -> IDLE. Encoding is free; illegal states recover to IDLE.
//   IDLE: start=1 at edge E0 does the following.
//     M <= sign-extended multiplicand (WIDTH+1 bits). A <= 0. Q <= multiplier.
//     q_1 <= 0. count <= 0. State goes to RUN.
//     start=0 holds state. hi_out and lo_out keep their last result.
//   RUN: each edge performs one Booth step. count increments.
//     {Q[0],q_1}=01 gives A+M. 10 gives A-M. 00/11 gives no add.
//     A is WIDTH+1 bits; the add/sub wraps mod 2^(WIDTH+1).
//       Result: the M = -2^(WIDTH-1) case cannot overflow.
//     Then arithmetic right shift of {A,Q,q_1} by 1. A's MSB replicates.
//     At the edge where count = WIDTH-1, the final step executes and state goes to DONE.
//     On that same edge, hi_out <= A[WIDTH-1:0] and lo_out <= Q (post-shift values).
//   DONE: done=1 for exactly this cycle. The next edge goes to IDLE unconditionally.
//   Latency: done is high in the cycle after edge E0+WIDTH (E0 + 32 for WIDTH=32).
//     Back-to-back throughput is one result per WIDTH+2 cycles.
//   start while busy (RUN or DONE): ignored. No queueing. Operands are not re-sampled.
//   Operand inputs may change freely after E0. Result depends only on values at E0.
//   start held high continuously: a new operation is accepted on the first IDLE edge after DONE.
//   clear mid-RUN/DONE: the operation is aborted. All outputs return to reset values.
//     No done pulse is produced.
//   Result is the exact signed two's-complement 2*WIDTH-bit product for all operand pairs.
//   Outputs busy/done/hi_out/lo_out are registered. There are no combinational input-to-output paths.
// TESTING
//   6 * 7 -> done exactly 32 edges after start edge; hi=0x00000000 lo=0x0000002A.
//   -3 (0xFFFFFFFD) * 5 -> hi=0xFFFFFFFF lo=0xFFFFFFF1.
//   -1 * -1 -> hi=0x00000000 lo=0x00000001.
//   0x80000000 * 0x80000000 -> hi=0x40000000 lo=0x00000000.
//   0x80000000 * 1 -> hi=0xFFFFFFFF lo=0x80000000 (overflow corner).
//   start pulsed at step 5 with new operands -> ignored; original 6*7 result still returned.
//   clear at step 10 -> busy=0 done=0 hi=lo=0 immediately (async), no done pulse.
//     Then start 0x7FFFFFFF*2 -> hi=0x00000000 lo=0xFFFFFFFE.
//   start held high -> done pulses every 34 cycles. busy low for one cycle between operations.
//   Random signed pairs (>=1000) compared against a $signed reference model.

Source files
------------

// File: rtl/booth_seq_mul.sv
// booth_seq_mul
// Sequential signed radix-2 Booth multiplier for the CPU MUL instruction.
// One Booth step per clock; start/busy/done handshake with the control unit.
// The 2*WIDTH-bit product is presented as hi/lo words for HI/LO writeback.
// All outputs are registered; there is no combinational input-to-output path.

module booth_seq_mul #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic [WIDTH-1:0] multiplicand,
    input  logic [WIDTH-1:0] multiplier,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);

    // Step counter only needs to reach WIDTH-1.
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;

    // M and A carry one extra bit so that M = -2^(WIDTH-1) never overflows.
    logic [WIDTH:0]   m_r;
    logic [WIDTH:0]   a_r;
    logic [WIDTH-1:0] q_r;
    logic             q1_r;
    logic [CW-1:0]    count_r;
    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] hi_r;
    logic [WIDTH-1:0] lo_r;

    logic [WIDTH:0]   m_nxt_s;
    logic [WIDTH:0]   a_nxt_s;
    logic [WIDTH-1:0] q_nxt_s;
    logic             q1_nxt_s;
    logic [CW-1:0]    count_nxt_s;
    logic             busy_nxt_s;
    logic             done_nxt_s;
    logic [WIDTH-1:0] hi_nxt_s;
    logic [WIDTH-1:0] lo_nxt_s;

    logic [WIDTH:0]   sum_s;
    logic [WIDTH:0]   a_shift_s;
    logic [WIDTH-1:0] q_shift_s;
    logic             q1_shift_s;

    assign busy   = busy_r;
    assign done   = done_r;
    assign hi_out = hi_r;
    assign lo_out = lo_r;

    // One Booth step: conditional add/sub of M, then arithmetic shift of {A,Q,q_1}.
    always_comb begin
        case ({q_r[0], q1_r})
            2'b01:   sum_s = a_r + m_r;
            2'b10:   sum_s = a_r - m_r;
            default: sum_s = a_r;
        endcase
        a_shift_s  = {sum_s[WIDTH], sum_s[WIDTH:1]};
        q_shift_s  = {sum_s[0], q_r[WIDTH-1:1]};
        q1_shift_s = q_r[0];
    end

    // Next-state and next-register values for the sequencer and datapath.
    always_comb begin
        state_nxt_s = state_r;
        m_nxt_s     = m_r;
        a_nxt_s     = a_r;
        q_nxt_s     = q_r;
        q1_nxt_s    = q1_r;
        count_nxt_s = count_r;
        hi_nxt_s    = hi_r;
        lo_nxt_s    = lo_r;

        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    m_nxt_s     = {multiplicand[WIDTH-1], multiplicand};
                    a_nxt_s     = {(WIDTH+1){1'b0}};
                    q_nxt_s     = multiplier;
                    q1_nxt_s    = 1'b0;
                    count_nxt_s = CNT_ZERO;
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                a_nxt_s     = a_shift_s;
                q_nxt_s     = q_shift_s;
                q1_nxt_s    = q1_shift_s;
                count_nxt_s = count_r + CNT_ONE;
                if (count_r == CNT_LAST) begin
                    // Final step: publish the post-shift product.
                    hi_nxt_s    = a_shift_s[WIDTH-1:0];
                    lo_nxt_s    = q_shift_s;
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase

        // Handshake outputs are registered copies of the next state.
        busy_nxt_s = (state_nxt_s != ST_IDLE);
        done_nxt_s = (state_nxt_s == ST_DONE);
    end

    // State, datapath and output registers with asynchronous clear.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_r <= ST_IDLE;
            m_r     <= {(WIDTH+1){1'b0}};
            a_r     <= {(WIDTH+1){1'b0}};
            q_r     <= {WIDTH{1'b0}};
            q1_r    <= 1'b0;
            count_r <= CNT_ZERO;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            hi_r    <= {WIDTH{1'b0}};
            lo_r    <= {WIDTH{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            m_r     <= m_nxt_s;
            a_r     <= a_nxt_s;
            q_r     <= q_nxt_s;
            q1_r    <= q1_nxt_s;
            count_r <= count_nxt_s;
            busy_r  <= busy_nxt_s;
            done_r  <= done_nxt_s;
            hi_r    <= hi_nxt_s;
            lo_r    <= lo_nxt_s;
        end
    end

endmodule
